// File: rtl/muldiv_pkg.sv
// Shared constants and enums for the RV32M multiply/divide unit.
package muldiv_pkg;

  localparam logic [6:0] OPCODE_OP     = 7'b0110011;
  localparam logic [6:0] FUNCT7_MULDIV = 7'h01;

  typedef enum logic [2:0] {
    F3_MUL, F3_MULH, F3_MULHSU, F3_MULHU, F3_DIV, F3_DIVU, F3_REM, F3_REMU
  } funct3_e;

  typedef enum logic [2:0] {
    ST_IDLE, ST_MUL, ST_DIV, ST_SPECIAL, ST_DONE
  } state_e;

  function automatic logic is_div_op(input funct3_e f);
    return f inside {F3_DIV, F3_DIVU, F3_REM, F3_REMU};
  endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Shared XLEN-step datapath: shift-add multiply or restoring divide on magnitudes.
module muldiv_iter #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_clear,
  input  logic            i_start,
  input  logic            i_div,
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_b,
  output logic            o_last,
  output logic [XLEN-1:0] o_hi,
  output logic [XLEN-1:0] o_lo
);

  localparam int CW = $clog2(XLEN) + 1;

  logic            r_run;
  logic            r_div;
  logic [CW-1:0]   r_cnt;
  logic [XLEN-1:0] r_a;
  logic [XLEN-1:0] r_hi;
  logic [XLEN-1:0] r_lo;
  logic [XLEN:0]   w_sum;
  logic [XLEN:0]   w_sh;
  logic [XLEN:0]   w_diff;

  // o_hi/o_lo are the accumulator values after the current step; the top
  // samples them on the last step so the sign fix-up lands in the same cycle.
  always_comb begin
    w_sum  = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_a} : '0);
    w_sh   = {r_hi, r_lo[XLEN-1]};
    w_diff = w_sh - {1'b0, r_a};
    o_hi   = '0;
    o_lo   = '0;
    if (r_div) begin
      o_hi = w_diff[XLEN] ? w_sh[XLEN-1:0] : w_diff[XLEN-1:0];
      o_lo = {r_lo[XLEN-2:0], ~w_diff[XLEN]};
    end else begin
      o_hi = w_sum[XLEN:1];
      o_lo = {w_sum[0], r_lo[XLEN-1:1]};
    end
    o_last = r_run && (r_cnt == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_run <= 1'b0;
      r_div <= 1'b0;
      r_cnt <= '0;
      r_a   <= '0;
      r_hi  <= '0;
      r_lo  <= '0;
    end else if (i_clear) begin
      r_run <= 1'b0;
    end else if (i_start) begin
      r_run <= 1'b1;
      r_div <= i_div;
      r_a   <= i_a;
      r_hi  <= '0;
      r_lo  <= i_b;
      r_cnt <= CW'(XLEN - 1);
    end else if (r_run) begin
      r_hi <= o_hi;
      r_lo <= o_lo;
      if (r_cnt == '0) r_run <= 1'b0;
      else             r_cnt <= r_cnt - 1'b1;
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// RV32M iterative multiply/divide unit: handshake FSM, decode, special cases, sign fix-up.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [6:0]      opcode,
  input  logic [2:0]      funct3,
  input  logic [6:0]      funct7,
  input  logic [XLEN-1:0] in1,
  input  logic [XLEN-1:0] in2,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out,
  output logic            busy
);

  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_e            r_state;
  funct3_e           r_f3;
  logic              r_neg;
  logic              r_rneg;
  logic [XLEN-1:0]   r_result;

  funct3_e           w_f3;
  logic              w_accept, w_legal, w_is_div, w_div0, w_ovf, w_special, w_start;
  logic              w_sa, w_sb, w_last;
  logic [XLEN-1:0]   w_mag1, w_mag2, w_spec_res, w_hi, w_lo, w_quo, w_rem, w_fix;
  logic [2*XLEN-1:0] w_prod;

  always_comb begin
    w_f3     = funct3_e'(funct3);
    w_legal  = (opcode == OPCODE_OP) && (funct7 == FUNCT7_MULDIV);
    w_accept = in_valid && in_ready && !flush;
    w_is_div = is_div_op(w_f3);
    w_sa     = (w_f3 inside {F3_MULH, F3_MULHSU, F3_DIV, F3_REM}) && in1[XLEN-1];
    w_sb     = (w_f3 inside {F3_MULH, F3_DIV, F3_REM}) && in2[XLEN-1];
    w_mag1   = w_sa ? -in1 : in1;
    w_mag2   = w_sb ? -in2 : in2;
    w_div0   = w_is_div && (in2 == '0);
    w_ovf    = (w_f3 inside {F3_DIV, F3_REM}) && (in1 == MOST_NEG) && (in2 == '1);
    w_special = w_div0 || w_ovf;
    w_spec_res = '0;
    if (w_div0)                 w_spec_res = (w_f3 inside {F3_DIV, F3_DIVU}) ? '1 : in1;
    else if (w_f3 == F3_DIV)    w_spec_res = MOST_NEG;
    w_start  = w_accept && w_legal && !w_special;
  end

  muldiv_iter #(.XLEN(XLEN)) u_iter (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clear (flush),
    .i_start (w_start),
    .i_div   (w_is_div),
    .i_a     (w_is_div ? w_mag2 : w_mag1),
    .i_b     (w_is_div ? w_mag1 : w_mag2),
    .o_last  (w_last),
    .o_hi    (w_hi),
    .o_lo    (w_lo)
  );

  // Divider leaves quotient in the low half, remainder in the high half.
  always_comb begin
    w_prod = r_neg ? -{w_hi, w_lo} : {w_hi, w_lo};
    w_quo  = r_neg ? -w_lo : w_lo;
    w_rem  = r_rneg ? -w_hi : w_hi;
    case (r_f3)
      F3_MUL:                     w_fix = w_prod[XLEN-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU: w_fix = w_prod[2*XLEN-1:XLEN];
      F3_DIV, F3_DIVU:            w_fix = w_quo;
      default:                    w_fix = w_rem;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_f3     <= F3_MUL;
      r_neg    <= 1'b0;
      r_rneg   <= 1'b0;
      r_result <= '0;
    end else if (flush) begin
      r_state <= ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: if (w_accept && w_legal) begin
          r_f3   <= w_f3;
          r_neg  <= w_sa ^ w_sb;
          r_rneg <= w_sa;
          if (w_special) begin
            r_result <= w_spec_res;
            r_state  <= ST_SPECIAL;
          end else begin
            r_state <= w_is_div ? ST_DIV : ST_MUL;
          end
        end
        ST_MUL, ST_DIV: if (w_last) begin
          r_result <= w_fix;
          r_state  <= ST_DONE;
        end
        ST_SPECIAL: r_state <= ST_DONE;
        ST_DONE:    if (out_ready) r_state <= ST_IDLE;
        default:    r_state <= ST_IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == ST_IDLE);
  assign busy      = (r_state != ST_IDLE);
  assign out_valid = (r_state == ST_DONE);
  assign out       = out_valid ? r_result : '0;

endmodule
